// File: rtl/pcie_usp_reg_completer_if.sv
// rtl/pcie_usp_reg_completer_if.sv - CQ request / CC completion stream pair of the UltraScale+ PCIe core
interface pcie_usp_reg_completer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int CQ_USER_WIDTH = 88,
  parameter int CC_USER_WIDTH = 33
);
  logic [DATA_WIDTH-1:0]    m_axis_cq_tdata;
  logic [KEEP_WIDTH-1:0]    m_axis_cq_tkeep;
  logic                     m_axis_cq_tlast;
  logic [CQ_USER_WIDTH-1:0] m_axis_cq_tuser;
  logic                     m_axis_cq_tvalid;
  logic                     m_axis_cq_tready;

  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep;
  logic                     s_axis_cc_tlast;
  logic [CC_USER_WIDTH-1:0] s_axis_cc_tuser;
  logic                     s_axis_cc_tvalid;
  logic                     s_axis_cc_tready;

  // master = PCIe core side, slave = completer side
  modport master (
    output m_axis_cq_tdata, m_axis_cq_tkeep, m_axis_cq_tlast, m_axis_cq_tuser, m_axis_cq_tvalid,
    input  m_axis_cq_tready,
    input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tuser, s_axis_cc_tvalid,
    output s_axis_cc_tready
  );

  modport slave (
    input  m_axis_cq_tdata, m_axis_cq_tkeep, m_axis_cq_tlast, m_axis_cq_tuser, m_axis_cq_tvalid,
    output m_axis_cq_tready,
    output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tuser, s_axis_cc_tvalid,
    input  s_axis_cc_tready
  );
endinterface

// File: rtl/pcie_usp_reg_completer.sv
// rtl/pcie_usp_reg_completer.sv - single-DW BAR register completer on the UltraScale+ CQ/CC streams
module pcie_usp_reg_completer #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int CQ_USER_WIDTH = 88,
  parameter int CC_USER_WIDTH = 33,
  parameter int REG_ADDR_W    = 4
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  pcie_usp_reg_completer_if.slave axis,
  output logic [1:0]            pcie_cq_np_req,
  output logic                  reg_wr_pulse,
  output logic [REG_ADDR_W-1:0] reg_wr_index
);
  localparam int REG_COUNT = 2 ** REG_ADDR_W;
  localparam int ADDR_HI   = (REG_ADDR_W + 1 > 6) ? REG_ADDR_W + 1 : 6;

  typedef enum logic [2:0] {S_IDLE, S_DESC1, S_DATA, S_DROP, S_CC0, S_CC1} state_t;

  state_t                  state;
  logic [ADDR_HI:2]        addr_q;
  logic [3:0]              be_q;
  logic [31:0]             regs [REG_COUNT];
  logic                    cq_tready_q;
  logic                    cc_tvalid_q;
  logic                    cc_tlast_q;
  logic [DATA_WIDTH-1:0]   cc_tdata_q;
  logic [KEEP_WIDTH-1:0]   cc_tkeep_q;
  logic [DATA_WIDTH-1:0]   cc1_data_q;
  logic [KEEP_WIDTH-1:0]   cc1_keep_q;
  logic [1:0]              np_req_q;
  logic                    wr_pulse_q;
  logic [REG_ADDR_W-1:0]   wr_index_q;
  logic [CC_USER_WIDTH-1:0] cc_tuser_zero;

  logic                  cq_fire;
  logic [REG_ADDR_W-1:0] idx;
  logic [1:0]            be_lsb;
  logic [1:0]            be_msb;
  logic [12:0]           byte_cnt;
  logic [10:0]           d_dcount;
  logic [3:0]            d_type;
  logic [15:0]           d_req_id;
  logic [7:0]            d_tag;
  logic [2:0]            d_tc;
  logic [2:0]            d_attr;
  logic                  d_sc;
  logic [31:0]           dw0;
  logic [31:0]           dw1;
  logic [31:0]           dw2;
  logic                  unused_bits;

  assign cq_fire  = axis.m_axis_cq_tvalid & cq_tready_q;
  assign idx      = addr_q[REG_ADDR_W+1:2];
  assign d_dcount = axis.m_axis_cq_tdata[10:0];
  assign d_type   = axis.m_axis_cq_tdata[14:11];
  assign d_req_id = axis.m_axis_cq_tdata[31:16];
  assign d_tag    = axis.m_axis_cq_tdata[39:32];
  assign d_tc     = axis.m_axis_cq_tdata[59:57];
  assign d_attr   = axis.m_axis_cq_tdata[62:60];
  assign d_sc     = (d_dcount == 11'd1);

  always_comb begin
    be_lsb = 2'd0;
    if (be_q[0])      be_lsb = 2'd0;
    else if (be_q[1]) be_lsb = 2'd1;
    else if (be_q[2]) be_lsb = 2'd2;
    else if (be_q[3]) be_lsb = 2'd3;
    be_msb = 2'd0;
    if (be_q[3])      be_msb = 2'd3;
    else if (be_q[2]) be_msb = 2'd2;
    else if (be_q[1]) be_msb = 2'd1;
  end

  // An empty first_be still reports one byte, as for a zero-length read
  assign byte_cnt = (be_q == 4'd0) ? 13'd1 : ({11'd0, be_msb - be_lsb} + 13'd1);

  assign dw0 = {3'b000, d_sc ? byte_cnt : 13'd0, 9'd0, addr_q[6:2], be_lsb};
  assign dw1 = {d_req_id, 2'b00, d_sc ? 3'b000 : 3'b001, d_sc ? 11'd1 : 11'd0};
  assign dw2 = {1'b0, d_attr, d_tc, 17'd0, d_tag};

  assign cc_tuser_zero = '0;
  assign unused_bits   = ^{axis.m_axis_cq_tdata, axis.m_axis_cq_tkeep,
                           axis.m_axis_cq_tuser[CQ_USER_WIDTH-1:0]};

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      cq_tready_q <= 1'b0;
      cc_tvalid_q <= 1'b0;
      cc_tlast_q  <= 1'b0;
      cc_tdata_q  <= '0;
      cc_tkeep_q  <= '0;
      cc1_data_q  <= '0;
      cc1_keep_q  <= '0;
      np_req_q    <= 2'b00;
      wr_pulse_q  <= 1'b0;
      wr_index_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      np_req_q   <= 2'b11;
      wr_pulse_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cq_tready_q <= 1'b1;
          if (cq_fire) begin
            addr_q <= axis.m_axis_cq_tdata[ADDR_HI:2];
            be_q   <= axis.m_axis_cq_tuser[3:0];
            state  <= axis.m_axis_cq_tlast ? S_IDLE : S_DESC1;
          end
        end
        S_DESC1: begin
          if (cq_fire) begin
            if (d_type == 4'b0001 && d_sc && !axis.m_axis_cq_tlast) begin
              state <= S_DATA;
            end else if (d_type == 4'b0000 && axis.m_axis_cq_tlast) begin
              // Both completion beats are built here; read data is frozen at this edge
              state       <= S_CC0;
              cq_tready_q <= 1'b0;
              cc_tvalid_q <= 1'b1;
              cc_tlast_q  <= 1'b0;
              cc_tdata_q  <= {dw1, dw0};
              cc_tkeep_q  <= 2'b11;
              cc1_data_q  <= d_sc ? {regs[idx], dw2} : {32'd0, dw2};
              cc1_keep_q  <= d_sc ? 2'b11 : 2'b01;
            end else begin
              state <= axis.m_axis_cq_tlast ? S_IDLE : S_DROP;
            end
          end
        end
        S_DATA: begin
          if (cq_fire) begin
            if (axis.m_axis_cq_tkeep[0] && axis.m_axis_cq_tlast) begin
              for (int b = 0; b < 4; b++)
                if (be_q[b]) regs[idx][8*b +: 8] <= axis.m_axis_cq_tdata[8*b +: 8];
              wr_pulse_q <= 1'b1;
              wr_index_q <= idx;
              state      <= S_IDLE;
            end else begin
              state <= axis.m_axis_cq_tlast ? S_IDLE : S_DROP;
            end
          end
        end
        S_DROP: begin
          if (cq_fire && axis.m_axis_cq_tlast) state <= S_IDLE;
        end
        S_CC0: begin
          if (axis.s_axis_cc_tready) begin
            cc_tdata_q <= cc1_data_q;
            cc_tkeep_q <= cc1_keep_q;
            cc_tlast_q <= 1'b1;
            state      <= S_CC1;
          end
        end
        S_CC1: begin
          if (axis.s_axis_cc_tready) begin
            cc_tvalid_q <= 1'b0;
            cc_tlast_q  <= 1'b0;
            cc_tdata_q  <= '0;
            cc_tkeep_q  <= '0;
            cq_tready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign axis.m_axis_cq_tready = cq_tready_q;
  assign axis.s_axis_cc_tdata  = cc_tdata_q;
  assign axis.s_axis_cc_tkeep  = cc_tkeep_q;
  assign axis.s_axis_cc_tlast  = cc_tlast_q;
  assign axis.s_axis_cc_tuser  = cc_tuser_zero;
  assign axis.s_axis_cc_tvalid = cc_tvalid_q;
  assign pcie_cq_np_req        = np_req_q;
  assign reg_wr_pulse          = wr_pulse_q;
  assign reg_wr_index          = wr_index_q;
endmodule

// File: tb/tb_pcie_usp_reg_completer.sv
// tb/tb_pcie_usp_reg_completer.sv - directed self-checking bench for pcie_usp_reg_completer
module tb_pcie_usp_reg_completer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] np_req;
  logic       pulse;
  logic [3:0] widx;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pcie_usp_reg_completer_if axis ();

  pcie_usp_reg_completer dut (
    .user_clk       (clk),
    .user_reset_n   (rst_n),
    .axis           (axis),
    .pcie_cq_np_req (np_req),
    .reg_wr_pulse   (pulse),
    .reg_wr_index   (widx)
  );

  function automatic logic [63:0] desc(input logic [10:0] dc, input logic [3:0] ty,
                                       input logic [15:0] rid, input logic [7:0] tag,
                                       input logic [2:0] tc, input logic [2:0] attr);
    return {1'b0, attr, tc, 17'd0, tag, rid, 1'b0, ty, dc};
  endfunction

  function automatic logic [66:0] cc_now();
    return {axis.s_axis_cc_tdata, axis.s_axis_cc_tkeep, axis.s_axis_cc_tlast};
  endfunction

  // Drives one CQ beat from a negedge and returns at the negedge after the handshake
  task automatic beat(input logic [63:0] d, input logic [1:0] k, input logic l,
                      input logic [3:0] be, output logic to);
    logic hs;
    int   n;
    axis.m_axis_cq_tdata  = d;
    axis.m_axis_cq_tkeep  = k;
    axis.m_axis_cq_tlast  = l;
    axis.m_axis_cq_tuser  = {84'd0, be};
    axis.m_axis_cq_tvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      @(posedge clk);
      hs = axis.m_axis_cq_tready;
      n++;
    end
    @(negedge clk);
    axis.m_axis_cq_tvalid = 1'b0;
    axis.m_axis_cq_tlast  = 1'b0;
    to = !hs;
  endtask

  task automatic send_write(input logic [63:0] addr, input logic [3:0] be, input logic [31:0] data,
                            input logic [10:0] dc, output logic to, output logic pulse_seen,
                            output logic [4:0] end_pulse);
    logic t;
    to = 1'b0;
    pulse_seen = 1'b0;
    beat(addr, 2'b11, 1'b0, be, t);                                  to |= t; pulse_seen |= pulse;
    beat(desc(dc, 4'b0001, 16'h0, 8'h0, 3'd0, 3'd0), 2'b11, 1'b0, be, t); to |= t; pulse_seen |= pulse;
    if (dc == 11'd1) begin
      beat({32'd0, data}, 2'b01, 1'b1, be, t);                       to |= t; pulse_seen |= pulse;
    end else begin
      for (int i = 0; i < 3; i++) begin
        beat({data, data}, 2'b11, i == 2, be, t);                    to |= t; pulse_seen |= pulse;
      end
    end
    end_pulse = {pulse, widx};
  endtask

  task automatic send_read(input logic [63:0] addr, input logic [3:0] be, input logic [10:0] dc,
                           input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                           input logic [2:0] attr, output logic to);
    logic t;
    beat(addr, 2'b11, 1'b0, be, t);
    to = t;
    beat(desc(dc, 4'b0000, rid, tag, tc, attr), 2'b11, 1'b1, be, t);
    to |= t;
  endtask

  // Collects both completion beats with cc_tready held high; lat counts negedges waited
  task automatic capture_cc(output logic [66:0] b0, output logic [66:0] b1, output int lat);
    lat = 0;
    while (!axis.s_axis_cc_tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    b0 = cc_now();
    @(negedge clk);
    b1 = cc_now();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [72:0] obs;
    repeat (3) @(negedge clk);
    obs = {axis.m_axis_cq_tready, axis.s_axis_cc_tvalid, cc_now(), np_req, pulse};
    n_checks++;
    if (obs !== 73'd0 || axis.s_axis_cc_tuser !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h tuser %h, expected all zero", obs, axis.s_axis_cc_tuser);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({np_req, axis.m_axis_cq_tready} !== 3'b111) begin
      n_fail++;
      $display("FAIL after_release: np_req %b tready %b, expected 11 1", np_req, axis.m_axis_cq_tready);
    end
  endtask

  task automatic test_write_read();
    logic to, ps;
    logic [4:0] ep;
    logic [66:0] b0, b1;
    int lat;
    send_write(64'h8, 4'hF, 32'hDEADBEEF, 11'd1, to, ps, ep);
    n_checks++;
    if ({to, ep} !== {1'b0, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL write_pulse: timeout %b pulse/index %h, expected 0 and 12", to, ep);
    end
    @(negedge clk);
    n_checks++;
    if (pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: pulse %b, expected 0", pulse);
    end
    send_read(64'h8, 4'hF, 11'd1, 16'hABCD, 8'h11, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if ({to, lat} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL read_latency: timeout %b lat %0d, expected 0 0", to, lat);
    end
    n_checks++;
    if (b0 !== {64'hABCD0001_00040008, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL sc_cc0: got %h, expected %h", b0, {64'hABCD0001_00040008, 2'b11, 1'b0});
    end
    n_checks++;
    if (b1 !== {64'hDEADBEEF_00000011, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL sc_cc1: got %h, expected %h", b1, {64'hDEADBEEF_00000011, 2'b11, 1'b1});
    end
  endtask

  task automatic test_byte_enable();
    logic to, ps;
    logic [4:0] ep;
    logic [66:0] b0, b1;
    int lat;
    send_write(64'h0, 4'b0110, 32'h11223344, 11'd1, to, ps, ep);
    send_read(64'h0, 4'b0110, 11'd1, 16'h0102, 8'h22, 3'b101, 3'b011, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if (b0 !== {64'h01020001_00020001, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL be_cc0: got %h, expected %h", b0, {64'h01020001_00020001, 2'b11, 1'b0});
    end
    n_checks++;
    if (b1 !== {64'h00223300_3A000022, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL be_cc1: got %h, expected %h", b1, {64'h00223300_3A000022, 2'b11, 1'b1});
    end
  endtask

  task automatic test_unsupported();
    logic to;
    logic [66:0] b0, b1;
    int lat;
    send_read(64'h4, 4'hF, 11'd2, 16'h1234, 8'h5A, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if (b0 !== {64'h12340800_00000004, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL ur_cc0: got %h, expected %h", b0, {64'h12340800_00000004, 2'b11, 1'b0});
    end
    n_checks++;
    if (b1 !== {64'h00000000_0000005A, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL ur_cc1: got %h, expected %h", b1, {64'h00000000_0000005A, 2'b01, 1'b1});
    end
  endtask

  task automatic test_backpressure();
    logic to, stable;
    logic [66:0] b;
    axis.s_axis_cc_tready = 1'b0;
    send_read(64'h8, 4'hF, 11'd1, 16'h0001, 8'h33, 3'd0, 3'd0, to);
    stable = axis.s_axis_cc_tvalid && !to;
    for (int i = 0; i < 10; i++) begin
      if (cc_now() !== {64'h00010001_00040008, 2'b11, 1'b0} || !axis.s_axis_cc_tvalid
          || axis.m_axis_cq_tready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: cc %h tready %b, expected CC0 held with cq_tready 0",
               cc_now(), axis.m_axis_cq_tready);
    end
    axis.s_axis_cc_tready = 1'b1;
    @(negedge clk);
    b = cc_now();
    n_checks++;
    if ({axis.s_axis_cc_tvalid, b} !== {1'b1, 64'hDEADBEEF_00000033, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_cc1: got %b %h, expected 1 %h", axis.s_axis_cc_tvalid, b,
               {64'hDEADBEEF_00000033, 2'b11, 1'b1});
    end
    @(negedge clk);
    n_checks++;
    if ({axis.s_axis_cc_tvalid, axis.m_axis_cq_tready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_end: valid %b cq_tready %b, expected 0 1",
               axis.s_axis_cc_tvalid, axis.m_axis_cq_tready);
    end
  endtask

  task automatic test_multi_beat_write();
    logic to, ps;
    logic [4:0] ep;
    logic [66:0] b0, b1;
    int lat;
    send_write(64'hC, 4'hF, 32'hCAFEF00D, 11'd4, to, ps, ep);
    @(negedge clk);
    ps |= pulse;
    n_checks++;
    if ({to, ps} !== 2'b00) begin
      n_fail++;
      $display("FAIL multi_no_write: timeout %b pulse_seen %b, expected 0 0", to, ps);
    end
    send_read(64'hC, 4'hF, 11'd1, 16'h0077, 8'h66, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if ({to, b0, b1} !== {1'b0, 64'h00770001_0004000C, 3'b110, 64'h00000000_00000066, 3'b111}) begin
      n_fail++;
      $display("FAIL multi_readback: got %b %h %h, expected 0 %h %h", to, b0, b1,
               {64'h00770001_0004000C, 3'b110}, {64'h00000000_00000066, 3'b111});
    end
  endtask

  task automatic test_alias_and_zero_be();
    logic to;
    logic [66:0] b0, b1;
    int lat;
    send_read(64'h48, 4'hF, 11'd1, 16'h0055, 8'h44, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if ({b0, b1} !== {64'h00550001_00040048, 3'b110, 64'hDEADBEEF_00000044, 3'b111}) begin
      n_fail++;
      $display("FAIL alias_read: got %h %h, expected %h %h", b0, b1,
               {64'h00550001_00040048, 3'b110}, {64'hDEADBEEF_00000044, 3'b111});
    end
    send_read(64'h8, 4'h0, 11'd1, 16'h0009, 8'h01, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if (b0 !== {64'h00090001_00010008, 3'b110}) begin
      n_fail++;
      $display("FAIL zero_be_cc0: got %h, expected %h", b0, {64'h00090001_00010008, 3'b110});
    end
  endtask

  task automatic test_reset_mid();
    logic to, seen;
    logic [72:0] obs;
    logic [66:0] b0, b1;
    int lat;
    axis.s_axis_cc_tready = 1'b0;
    send_read(64'h8, 4'hF, 11'd1, 16'h0BAD, 8'h77, 3'd0, 3'd0, to);
    axis.s_axis_cc_tready = 1'b1;
    @(negedge clk);
    axis.s_axis_cc_tready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({axis.s_axis_cc_tvalid, axis.s_axis_cc_tlast} !== 2'b11) begin
      n_fail++;
      $display("FAIL cc1_stall: valid %b last %b, expected 1 1",
               axis.s_axis_cc_tvalid, axis.s_axis_cc_tlast);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {axis.m_axis_cq_tready, axis.s_axis_cc_tvalid, cc_now(), np_req, pulse};
    n_checks++;
    if (obs !== 73'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h, expected all zero", obs);
    end
    axis.s_axis_cc_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= axis.s_axis_cc_tvalid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_completion: cc_tvalid seen %b, expected 0", seen);
    end
    send_read(64'h8, 4'hF, 11'd1, 16'h0002, 8'h08, 3'd0, 3'd0, to);
    capture_cc(b0, b1, lat);
    n_checks++;
    if ({to, b1} !== {1'b0, 64'h00000000_00000008, 3'b111}) begin
      n_fail++;
      $display("FAIL regs_cleared: got %b %h, expected 0 %h", to, b1, {64'h00000000_00000008, 3'b111});
    end
  endtask

  initial begin
    axis.m_axis_cq_tdata  = '0;
    axis.m_axis_cq_tkeep  = '0;
    axis.m_axis_cq_tlast  = 1'b0;
    axis.m_axis_cq_tuser  = '0;
    axis.m_axis_cq_tvalid = 1'b0;
    axis.s_axis_cc_tready = 1'b1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_unsupported();
    test_backpressure();
    test_multi_beat_write();
    test_alias_and_zero_be();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
